reorder_return_buffer: RTL and testbench
========================================

Name: reorder_return_buffer

Overview:
- Completion-reorder buffer for split-transaction request/response paths such as an MMIO bridge onto a mesh network.
- A requester allocates a tag (slot ID) in order. Responses write data back by tag in any order.
- Data is dequeued strictly in allocation order.
- Lets a bridge return responses in order while the network completes them out of order.

Parameters:
- width_p, 32, data bits per entry.
- els_p, 8, number of entries (>=2, need not be a power of 2).
- id_width_lp (localparam), max(1, ceil(log2(els_p))), tag width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset (0 = reset asserted).
- fifo_alloc_id_o  out  id_width_lp  next tag to be allocated.
- fifo_alloc_v_o  out  1  a free slot exists.
- fifo_alloc_yumi_i  in  1  consume the offered tag; legal only while fifo_alloc_v_o=1.
- write_id_i  in  id_width_lp  tag of the returning response.
- write_data_i  in  width_p  response data.
- write_v_i  in  1  write strobe; always accepted, no backpressure.
- fifo_deq_data_o  out  width_p  data of the oldest allocated slot.
- fifo_deq_v_o  out  1  the oldest slot has been written.
- fifo_deq_yumi_i  in  1  dequeue the oldest slot; legal only while fifo_deq_v_o=1.
- empty_o  out  1  no slots allocated.

Behaviour:
- State:
  - alloc pointer wp and dequeue pointer rp, each 0..els_p-1, wrapping from els_p-1 to 0.
  - Occupancy count cnt, 0..els_p.
  - Per-slot written bit vld[els_p].
  - Data memory mem[els_p][width_p].
- Reset (reset_i=0, asynchronous): wp=rp=0, cnt=0, vld all 0, mem all 0. Outputs during and after reset:
  - fifo_alloc_v_o=1
  - fifo_alloc_id_o=0
  - fifo_deq_v_o=0
  - fifo_deq_data_o=0
  - empty_o=1
- Reset asserted mid-operation discards all outstanding tags and data immediately.
- Combinational outputs:
  - fifo_alloc_id_o=wp
  - fifo_alloc_v_o=(cnt!=els_p)
  - empty_o=(cnt==0)
  - fifo_deq_v_o=(cnt!=0) & vld[rp]
  - fifo_deq_data_o=mem[rp] (asynchronous read of the registered array)
- Allocate: fifo_alloc_yumi_i=1 → wp advances by 1 with wrap, cnt+1.
- Write: write_v_i=1 → mem[write_id_i]<=write_data_i and vld[write_id_i]<=1 on the same edge. Latency: written in cycle N, visible on fifo_deq_v_o/fifo_deq_data_o in cycle N+1.
- Dequeue: fifo_deq_yumi_i=1 → vld[rp]<=0, rp advances with wrap, cnt-1.
- Simultaneous events, same edge:
  - Alloc and dequeue together: cnt unchanged, both pointers advance.
  - Write plus dequeue to different slots: both take effect.
  - Write to a slot that is dequeued on the same edge cannot occur in legal use, because dequeue requires vld already set. If it occurs anyway, the clear wins.
- Full (cnt==els_p): fifo_alloc_v_o=0; a dequeue that edge frees one slot for the following cycle, with no same-cycle bypass.
- Empty: fifo_deq_v_o=0 even if a stale vld bit is set.
- Out-of-order writes stay parked until all older slots have been written and dequeued.
- Illegal use without the checks feature:
  - Writes to unallocated or already-written tags are performed as normal writes.
  - yumi without the matching valid has undefined results.

Optional Feature:
- Macro REORDER_RETURN_BUFFER_CHECKS_EN.
- When defined, simulation-only checks on each rising clock edge while reset_i=1 call $error on:
  - fifo_alloc_yumi_i=1 while fifo_alloc_v_o=0
  - fifo_deq_yumi_i=1 while fifo_deq_v_o=0
  - write_v_i to a tag not currently allocated, meaning outside the circular range [rp, wp) with cnt taken into account
  - write_v_i to a tag whose vld bit is already 1
  - write_id_i >= els_p
- Functional behaviour is otherwise identical.
- When undefined, no checking logic is compiled.

Test Plan:
- Reset: hold reset_i=0 → alloc_v=1, alloc_id=0, deq_v=0, empty=1, deq_data=0. Release → same values.
- In-order single: els_p=4. Alloc tag 0, write id 0 data 0xA5A5_0001 → deq_v=1 next cycle with deq_data=0xA5A5_0001. Dequeue → empty=1.
- Out-of-order: alloc tags 0,1,2; write id 2=0x22, then id 1=0x11 → deq_v stays 0. Write id 0=0x00 → dequeue yields 0x00, 0x11, 0x22 in consecutive cycles.
- Full: els_p=4, allocate 4 tags → alloc_v=0. Write id 0 and dequeue it → alloc_v=1 the next cycle with alloc_id=0 (wrap).
- Simultaneous: with slot rp written, assert alloc yumi and deq yumi on the same edge → cnt unchanged, alloc_id and rp each +1.
- Wrap stress: els_p=3, 20 alloc/write/dequeue rounds with writes in reverse order → data returned in allocation order, no loss or duplication.

Source files
------------

// File: rtl/reorder_return_buffer_if.sv
// Bundles the allocate / write-back / dequeue signals of reorder_return_buffer.
// slave is the buffer side; master is the requester/responder side.
interface reorder_return_buffer_if #(
  parameter int width_p = 32,
  parameter int els_p   = 8
);
  localparam int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  // Handshakes: *_v_o advertises an offer that may be taken by pulsing the
  // matching *_yumi_i in the same cycle; yumi without v is illegal. write_v_i
  // is an unconditional strobe that is always accepted.
  logic [id_width_lp-1:0] fifo_alloc_id_o;
  logic                   fifo_alloc_v_o;
  logic                   fifo_alloc_yumi_i;
  logic [id_width_lp-1:0] write_id_i;
  logic [width_p-1:0]     write_data_i;
  logic                   write_v_i;
  logic [width_p-1:0]     fifo_deq_data_o;
  logic                   fifo_deq_v_o;
  logic                   fifo_deq_yumi_i;
  logic                   empty_o;

  modport slave (
    output fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
    input  fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
  );

  modport master (
    input  fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
    output fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
  );
endinterface

// File: rtl/reorder_return_buffer.sv
// Completion-reorder buffer: tags allocated in order, written back in any order,
// dequeued in allocation order. Define REORDER_RETURN_BUFFER_CHECKS_EN for usage checks.
module reorder_return_buffer #(
  parameter int width_p = 32,
  parameter int els_p   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  reorder_return_buffer_if.slave bus
);
  localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [id_width_lp-1:0]  r_wp;
  logic [id_width_lp-1:0]  r_rp;
  logic [cnt_width_lp-1:0] r_cnt;
  logic [els_p-1:0]        r_vld;
  logic [width_p-1:0]      r_mem [els_p];

  logic [id_width_lp-1:0]  w_wp_next;
  logic [id_width_lp-1:0]  w_rp_next;
  logic [els_p-1:0]        w_wr_sel;
  logic [els_p-1:0]        w_deq_sel;
  logic                    w_alloc;
  logic                    w_deq;

  assign w_alloc   = bus.fifo_alloc_yumi_i;
  assign w_deq     = bus.fifo_deq_yumi_i;
  assign w_wp_next = (r_wp == last_id_lp) ? '0 : r_wp + id_width_lp'(1);
  assign w_rp_next = (r_rp == last_id_lp) ? '0 : r_rp + id_width_lp'(1);

  // Tags at or beyond els_p select nothing, so they are dropped silently.
  always_comb begin
    w_wr_sel  = '0;
    w_deq_sel = '0;
    for (int i = 0; i < els_p; i++) begin
      w_wr_sel[i]  = bus.write_v_i && (bus.write_id_i == id_width_lp'(i));
      w_deq_sel[i] = w_deq && (r_rp == id_width_lp'(i));
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
      for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
    end else begin
      if (w_alloc) r_wp <= w_wp_next;
      if (w_deq)   r_rp <= w_rp_next;
      case ({w_alloc, w_deq})
        2'b10:   r_cnt <= r_cnt + cnt_width_lp'(1);
        2'b01:   r_cnt <= r_cnt - cnt_width_lp'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Clear beats set when a write lands on the slot being dequeued.
      r_vld <= (r_vld | w_wr_sel) & ~w_deq_sel;
      for (int i = 0; i < els_p; i++) begin
        if (w_wr_sel[i]) r_mem[i] <= bus.write_data_i;
      end
    end
  end

  assign bus.fifo_alloc_id_o = r_wp;
  assign bus.fifo_alloc_v_o  = (r_cnt != full_cnt_lp);
  assign bus.empty_o         = (r_cnt == '0);
  assign bus.fifo_deq_v_o    = (r_cnt != '0) && r_vld[r_rp];
  assign bus.fifo_deq_data_o = r_mem[r_rp];

`ifdef REORDER_RETURN_BUFFER_CHECKS_EN
  always @(posedge clk_i) begin : usage_checks
    int off;
    off = (int'(bus.write_id_i) >= int'(r_rp)) ? int'(bus.write_id_i) - int'(r_rp)
                                               : int'(bus.write_id_i) + els_p - int'(r_rp);
    if (reset_i) begin
      if (w_alloc && !bus.fifo_alloc_v_o)
        $error("reorder_return_buffer: alloc yumi while no free slot");
      if (w_deq && !bus.fifo_deq_v_o)
        $error("reorder_return_buffer: deq yumi while oldest slot not ready");
      if (bus.write_v_i && int'(bus.write_id_i) >= els_p)
        $error("reorder_return_buffer: write tag %0d out of range", bus.write_id_i);
      else if (bus.write_v_i && off >= int'(r_cnt))
        $error("reorder_return_buffer: write to unallocated tag %0d", bus.write_id_i);
      else if (bus.write_v_i && r_vld[bus.write_id_i])
        $error("reorder_return_buffer: write to already-written tag %0d", bus.write_id_i);
    end
  end
`else
  // Usage checks compiled out.
`endif

endmodule

// File: tb/tb_reorder_return_buffer.sv
// Directed and randomized scenarios for reorder_return_buffer (els_p=4 and els_p=3),
// with an in-order expected-data queue compared at every dequeue.
module tb_reorder_return_buffer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reorder_return_buffer_if #(.width_p(32), .els_p(4)) bus4();
  reorder_return_buffer_if #(.width_p(32), .els_p(3)) bus3();

  reorder_return_buffer #(.width_p(32), .els_p(4)) u_dut4 (.clk_i(clk), .reset_i(rst_n), .bus(bus4));
  reorder_return_buffer #(.width_p(32), .els_p(3)) u_dut3 (.clk_i(clk), .reset_i(rst_n), .bus(bus3));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_wp4;
  logic [1:0]  exp_wp3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- clock/reset helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.fifo_alloc_yumi_i = 1'b0; bus4.write_v_i = 1'b0; bus4.write_id_i = '0;
    bus4.write_data_i = '0;        bus4.fifo_deq_yumi_i = 1'b0;
    bus3.fifo_alloc_yumi_i = 1'b0; bus3.write_v_i = 1'b0; bus3.write_id_i = '0;
    bus3.write_data_i = '0;        bus3.fifo_deq_yumi_i = 1'b0;
  endtask

  // ---------------- driver tasks (els_p=4 instance) ----------------
  task automatic alloc4(input logic [31:0] d, output logic [1:0] tag);
    checks++;
    if (bus4.fifo_alloc_v_o !== 1'b1) begin
      errors++; $display("FAIL alloc4_v: got %b want 1", bus4.fifo_alloc_v_o);
    end
    checks++;
    if (bus4.fifo_alloc_id_o !== exp_wp4) begin
      errors++; $display("FAIL alloc4_id: got %0d want %0d", bus4.fifo_alloc_id_o, exp_wp4);
    end
    tag = exp_wp4;
    exp_q.push_back(d);
    bus4.fifo_alloc_yumi_i = 1'b1;
    step();
    bus4.fifo_alloc_yumi_i = 1'b0;
    exp_wp4 = (exp_wp4 == 2'd3) ? 2'd0 : exp_wp4 + 2'd1;
  endtask

  task automatic write4(input logic [1:0] id, input logic [31:0] d);
    bus4.write_v_i = 1'b1; bus4.write_id_i = id; bus4.write_data_i = d;
    step();
    bus4.write_v_i = 1'b0;
  endtask

  task automatic deq4(input string name);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b1) begin
      errors++; $display("FAIL %s_deq_v: got %b want 1", name, bus4.fifo_deq_v_o);
    end else begin
      checks++;
      if (bus4.fifo_deq_data_o !== e) begin
        errors++; $display("FAIL %s_deq_data: got %h want %h", name, bus4.fifo_deq_data_o, e);
      end
      bus4.fifo_deq_yumi_i = 1'b1;
      step();
      bus4.fifo_deq_yumi_i = 1'b0;
    end
  endtask

  task automatic deq3(input string name);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (bus3.fifo_deq_v_o !== 1'b1) begin
      errors++; $display("FAIL %s_deq_v: got %b want 1", name, bus3.fifo_deq_v_o);
    end else begin
      checks++;
      if (bus3.fifo_deq_data_o !== e) begin
        errors++; $display("FAIL %s_deq_data: got %h want %h", name, bus3.fifo_deq_data_o, e);
      end
      bus3.fifo_deq_yumi_i = 1'b1;
      step();
      bus3.fifo_deq_yumi_i = 1'b0;
    end
  endtask

  task automatic check_idle4(input string name);
    checks++;
    if (bus4.fifo_alloc_v_o !== 1'b1) begin
      errors++; $display("FAIL %s_alloc_v: got %b want 1", name, bus4.fifo_alloc_v_o);
    end
    checks++;
    if (bus4.fifo_alloc_id_o !== 2'd0) begin
      errors++; $display("FAIL %s_alloc_id: got %0d want 0", name, bus4.fifo_alloc_id_o);
    end
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b0) begin
      errors++; $display("FAIL %s_deq_v: got %b want 0", name, bus4.fifo_deq_v_o);
    end
    checks++;
    if (bus4.fifo_deq_data_o !== 32'h0) begin
      errors++; $display("FAIL %s_deq_data: got %h want 0", name, bus4.fifo_deq_data_o);
    end
    checks++;
    if (bus4.empty_o !== 1'b1) begin
      errors++; $display("FAIL %s_empty: got %b want 1", name, bus4.empty_o);
    end
  endtask

  task automatic check_empty4(input string name);
    checks++;
    if (bus4.empty_o !== 1'b1) begin
      errors++; $display("FAIL %s_empty: got %b want 1", name, bus4.empty_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_wp4 = 2'd0;
    exp_wp3 = 2'd0;
    repeat (3) step();
    check_idle4("reset_held");
    checks++;
    if (bus3.empty_o !== 1'b1 || bus3.fifo_alloc_v_o !== 1'b1) begin
      errors++; $display("FAIL reset3: empty %b alloc_v %b want 1 1", bus3.empty_o, bus3.fifo_alloc_v_o);
    end
    rst_n = 1'b1;
    step();
    check_idle4("reset_released");
  endtask

  task automatic test_in_order();
    logic [1:0] t;
    alloc4(32'hA5A5_0001, t);
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b0 || bus4.empty_o !== 1'b0) begin
      errors++; $display("FAIL inorder_pending: deq_v %b empty %b want 0 0", bus4.fifo_deq_v_o, bus4.empty_o);
    end
    write4(t, 32'hA5A5_0001);
    deq4("inorder");
    check_empty4("inorder_after");
  endtask

  task automatic test_out_of_order();
    logic [1:0] t0, t1, t2;
    alloc4(32'h0000_0000, t0);
    alloc4(32'h0000_0011, t1);
    alloc4(32'h0000_0022, t2);
    write4(t2, 32'h0000_0022);
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b0) begin
      errors++; $display("FAIL ooo_park2: deq_v got %b want 0", bus4.fifo_deq_v_o);
    end
    write4(t1, 32'h0000_0011);
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b0) begin
      errors++; $display("FAIL ooo_park1: deq_v got %b want 0", bus4.fifo_deq_v_o);
    end
    write4(t0, 32'h0000_0000);
    deq4("ooo0");
    deq4("ooo1");
    deq4("ooo2");
    check_empty4("ooo_after");
  endtask

  task automatic test_full();
    logic [1:0] t [4];
    for (int i = 0; i < 4; i++) alloc4(32'hF000_0000 + 32'(i), t[i]);
    checks++;
    if (bus4.fifo_alloc_v_o !== 1'b0) begin
      errors++; $display("FAIL full_alloc_v: got %b want 0", bus4.fifo_alloc_v_o);
    end
    write4(t[0], 32'hF000_0000);
    checks++;
    if (bus4.fifo_alloc_v_o !== 1'b0) begin
      errors++; $display("FAIL full_no_bypass: alloc_v got %b want 0", bus4.fifo_alloc_v_o);
    end
    deq4("full0");
    checks++;
    if (bus4.fifo_alloc_v_o !== 1'b1 || bus4.fifo_alloc_id_o !== exp_wp4) begin
      errors++; $display("FAIL full_freed: alloc_v %b id %0d want 1 %0d",
                         bus4.fifo_alloc_v_o, bus4.fifo_alloc_id_o, exp_wp4);
    end
    for (int i = 3; i >= 1; i--) write4(t[i], 32'hF000_0000 + 32'(i));
    deq4("full1");
    deq4("full2");
    deq4("full3");
    check_empty4("full_after");
  endtask

  task automatic test_simultaneous();
    logic [1:0] ta, tb, tc;
    logic [31:0] e;
    alloc4(32'h5100_000A, ta);
    write4(ta, 32'h5100_000A);
    alloc4(32'h5100_000B, tb);
    e = exp_q.pop_front();
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b1 || bus4.fifo_deq_data_o !== e) begin
      errors++; $display("FAIL simul_pre: deq_v %b data %h want 1 %h", bus4.fifo_deq_v_o, bus4.fifo_deq_data_o, e);
    end
    tc = exp_wp4;
    exp_q.push_back(32'h5100_000C);
    bus4.fifo_alloc_yumi_i = 1'b1;
    bus4.fifo_deq_yumi_i   = 1'b1;
    step();
    bus4.fifo_alloc_yumi_i = 1'b0;
    bus4.fifo_deq_yumi_i   = 1'b0;
    exp_wp4 = (exp_wp4 == 2'd3) ? 2'd0 : exp_wp4 + 2'd1;
    checks++;
    if (bus4.fifo_alloc_id_o !== exp_wp4) begin
      errors++; $display("FAIL simul_wp: alloc_id got %0d want %0d", bus4.fifo_alloc_id_o, exp_wp4);
    end
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b0 || bus4.empty_o !== 1'b0 || bus4.fifo_alloc_v_o !== 1'b1) begin
      errors++; $display("FAIL simul_state: deq_v %b empty %b alloc_v %b want 0 0 1",
                         bus4.fifo_deq_v_o, bus4.empty_o, bus4.fifo_alloc_v_o);
    end
    write4(tb, 32'h5100_000B);
    deq4("simul_b");
    write4(tc, 32'h5100_000C);
    deq4("simul_c");
    check_empty4("simul_after");
  endtask

  task automatic test_write_during_dequeue();
    logic [1:0] ta, tb;
    logic [31:0] e;
    alloc4(32'h3300_0001, ta);
    alloc4(32'h3300_0002, tb);
    write4(ta, 32'h3300_0001);
    e = exp_q.pop_front();
    checks++;
    if (bus4.fifo_deq_v_o !== 1'b1 || bus4.fifo_deq_data_o !== e) begin
      errors++; $display("FAIL wdeq_pre: deq_v %b data %h want 1 %h", bus4.fifo_deq_v_o, bus4.fifo_deq_data_o, e);
    end
    bus4.fifo_deq_yumi_i = 1'b1;
    bus4.write_v_i = 1'b1; bus4.write_id_i = tb; bus4.write_data_i = 32'h3300_0002;
    step();
    bus4.fifo_deq_yumi_i = 1'b0;
    bus4.write_v_i = 1'b0;
    deq4("wdeq_b");
    check_empty4("wdeq_after");
  endtask

  task automatic test_reset_mid();
    logic [1:0] t;
    alloc4(32'h7700_0001, t);
    write4(t, 32'h7700_0001);
    void'(alloc4_dummy());
    #2;
    rst_n = 1'b0;
    #1;
    check_idle4("reset_mid");
    exp_q.delete();
    exp_wp4 = 2'd0;
    exp_wp3 = 2'd0;
    step();
    rst_n = 1'b1;
    step();
    check_idle4("reset_mid_released");
  endtask

  function automatic int alloc4_dummy();
    return 0;
  endfunction

  task automatic test_wrap_stress();
    logic [1:0]  t [3];
    logic [31:0] d [3];
    int k;
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        checks++;
        if (bus3.fifo_alloc_v_o !== 1'b1 || bus3.fifo_alloc_id_o !== exp_wp3) begin
          errors++; $display("FAIL wrap_alloc r%0d: v %b id %0d want 1 %0d",
                             r, bus3.fifo_alloc_v_o, bus3.fifo_alloc_id_o, exp_wp3);
        end
        t[j] = exp_wp3;
        d[j] = $urandom;
        exp_q.push_back(d[j]);
        bus3.fifo_alloc_yumi_i = 1'b1;
        step();
        bus3.fifo_alloc_yumi_i = 1'b0;
        exp_wp3 = (exp_wp3 == 2'd2) ? 2'd0 : exp_wp3 + 2'd1;
      end
      if (k == 3) begin
        checks++;
        if (bus3.fifo_alloc_v_o !== 1'b0) begin
          errors++; $display("FAIL wrap_full r%0d: alloc_v got %b want 0", r, bus3.fifo_alloc_v_o);
        end
      end
      for (int j = k - 1; j >= 0; j--) begin
        bus3.write_v_i = 1'b1; bus3.write_id_i = t[j]; bus3.write_data_i = d[j];
        step();
        bus3.write_v_i = 1'b0;
        if (j > 0) begin
          checks++;
          if (bus3.fifo_deq_v_o !== 1'b0) begin
            errors++; $display("FAIL wrap_park r%0d: deq_v got %b want 0", r, bus3.fifo_deq_v_o);
          end
        end
      end
      for (int j = 0; j < k; j++) deq3("wrap");
      checks++;
      if (bus3.empty_o !== 1'b1) begin
        errors++; $display("FAIL wrap_empty r%0d: got %b want 1", r, bus3.empty_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full();
    test_simultaneous();
    test_write_during_dequeue();
    test_reset_mid();
    test_wrap_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
